// File: rtl/branch_target_lut_if.sv
// Bus bundle for the branch target lookup table.
// master drives lookup/write/clear requests; slave returns Target/TgtValid/Hit/Busy.
interface branch_target_lut_if #(
    parameter int AW = 4,
    parameter int PW = 10
);
    logic          LkEn;
    logic [AW-1:0] LkAddr;
    logic [PW-1:0] PC;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [PW-1:0] WrData;
    logic          WrRel;
    logic          ClrStart;
    logic [PW-1:0] Target;
    logic          TgtValid;
    logic          Hit;
    logic          Busy;

    modport master (
        output LkEn, LkAddr, PC,
        output WrEn, WrAddr, WrData, WrRel,
        output ClrStart,
        input  Target, TgtValid, Hit, Busy
    );

    modport slave (
        input  LkEn, LkAddr, PC,
        input  WrEn, WrAddr, WrData, WrRel,
        input  ClrStart,
        output Target, TgtValid, Hit, Busy
    );
endinterface

// File: rtl/branch_target_lut.sv
// Programmable branch-target table: index -> absolute or PC-relative target.
// Ports: Clk, Reset (sync, active-high), bus (slave: lookup, write, clear sweep).
module branch_target_lut #(
    parameter int AW = 4,
    parameter int PW = 10
) (
    input  logic                 Clk,
    input  logic                 Reset,
    branch_target_lut_if.slave   bus
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nx;
    logic          clr_en;
    logic          sweep;

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] rel_q;
    logic [PW-1:0]    data_q [DEPTH];

    logic          wr_ok;
    logic          fwd;
    logic          e_valid;
    logic          e_rel;
    logic [PW-1:0] e_data;
    logic          lk_hit;
    logic [PW-1:0] lk_tgt;

    logic          tv_q;
    logic          hit_q;
    logic [PW-1:0] tgt_q;

    // Clear-sweep FSM: state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Clear-sweep FSM: next state
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.ClrStart) begin
                    state_nx = SWEEP;
                    cnt_nx   = '0;
                end
            end
            SWEEP: begin
                clr_en = 1'b1;
                cnt_nx = cnt + 1'b1;
                if (&cnt) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign sweep = (state == SWEEP);

    // Writes are dropped while the sweep owns the valid bits
    assign wr_ok = bus.WrEn && !sweep;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid <= '0;
        end else begin
            if (clr_en) begin
                valid[cnt] <= 1'b0;
            end
            if (wr_ok) begin
                valid[bus.WrAddr] <= 1'b1;
            end
        end
    end

    // Payload storage is not reset; valid alone qualifies it
    always_ff @(posedge Clk) begin
        if (wr_ok) begin
            data_q[bus.WrAddr] <= bus.WrData;
            rel_q[bus.WrAddr]  <= bus.WrRel;
        end
    end

    // Write-first: a same-cycle write to the looked-up index wins
    assign fwd     = wr_ok && (bus.WrAddr == bus.LkAddr);
    assign e_valid = fwd | valid[bus.LkAddr];
    assign e_rel   = fwd ? bus.WrRel  : rel_q[bus.LkAddr];
    assign e_data  = fwd ? bus.WrData : data_q[bus.LkAddr];

    assign lk_hit = e_valid && !sweep;

    // Offset is full width, so plain modular add handles negatives
    always_comb begin
        lk_tgt = bus.PC + PW'(1);
        if (lk_hit) begin
            if (e_rel) begin
                lk_tgt = bus.PC + e_data;
            end else begin
                lk_tgt = e_data;
            end
        end
    end

    // Result register; Target/Hit hold between lookups
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tv_q  <= 1'b0;
            hit_q <= 1'b0;
            tgt_q <= '0;
        end else begin
            tv_q <= bus.LkEn;
            if (bus.LkEn) begin
                hit_q <= lk_hit;
                tgt_q <= lk_tgt;
            end
        end
    end

    assign bus.TgtValid = tv_q;
    assign bus.Hit      = hit_q;
    assign bus.Target   = tgt_q;
    assign bus.Busy     = sweep;
endmodule

// File: doc/branch_target_lut.md
# branch_target_lut

Programmable, parametrised branch-target lookup table for the fetch stage. It maps a short branch index carried in an instruction to a full-width PC target. Entries are written at run time rather than fixed at synthesis, and each entry is either absolute or PC-relative. Lookups are registered with one-cycle latency. Unprogrammed entries fall back to PC+1, and a counter-driven sweep clears the whole table.

## Interface
- AW, 4, index width; table depth is DEPTH = 2**AW
- PW, 10, PC / target width
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; clears all valid bits, aborts any sweep
- LkEn  in  1  lookup request this cycle
- LkAddr  in  AW  index to look up
- PC  in  PW  PC of the branch being resolved, sampled with LkEn
- WrEn  in  1  write one entry
- WrAddr  in  AW  entry to write
- WrData  in  PW  absolute target, or two's-complement offset when WrRel=1
- WrRel  in  1  entry mode: 0 absolute, 1 PC-relative
- ClrStart  in  1  start full-table clear sweep
- Target  out  PW  resolved target, valid when TgtValid=1
- TgtValid  out  1  Target holds a lookup result (one cycle after LkEn)
- Hit  out  1  qualifies TgtValid; 1 = programmed entry used, 0 = PC+1 fallback
- Busy  out  1  clear sweep in progress

## Operation
- Storage per entry: PW-bit data, rel bit, valid bit. Only valid bits are reset; data and rel bits are not reset.
- Lookup is computed from the entry at LkAddr and registered:
  - If valid and rel=0: Target = data.
  - If valid and rel=1: Target = (PC + data) mod 2**PW. The offset is full width, so no sign extension is needed. Wrap-around is silent.
  - If not valid: Target = (PC + 1) mod 2**PW and Hit = 0.
- Write: on WrEn, store data and rel at WrAddr and set valid.
- Write/lookup same cycle, same address: write-first. The lookup result uses WrData and WrRel, and Hit = 1.
- Clear sweep states:
  - IDLE -> SWEEP on ClrStart while IDLE. The counter starts at 0.
  - SWEEP: each cycle, clear valid[counter] and increment the counter.
  - SWEEP -> IDLE after clearing entry DEPTH-1.
  - ClrStart while SWEEP is ignored.
- During SWEEP:
  - Writes are dropped and do not set valid.
  - Lookups still complete but return the fallback: Hit = 0, Target = PC+1.
- Reset at any time forces IDLE, clears every valid bit, and sets counter = 0, TgtValid = 0, Hit = 0, Target = 0, Busy = 0.

## Timing
- Lookup latency is 1 cycle. LkEn in cycle n gives Target/Hit/TgtValid in cycle n+1. TgtValid is a single-cycle pulse per LkEn, and back-to-back lookups give one result per cycle.
- Target and Hit hold their last value when TgtValid = 0.
- A write in cycle n is visible to a lookup in cycle n (forwarded) and in every later cycle.
- Busy rises the cycle after ClrStart. It stays high for exactly DEPTH cycles (16 at AW=4) and falls the cycle after the last entry is cleared.
- A lookup issued in the first cycle after Busy falls sees a fully cleared table.
- Reset asserted in the same cycle as LkEn: TgtValid = 0 next cycle (reset wins).

## Test plan
- Reset, then look up all 16 indices with PC=100 -> each result Hit=0, Target=101; PC=1023 -> Target=0 (wrap).
- Write idx 0 abs 8, idx 4 abs 13, idx 5 rel 0x3FC (-4). Look up idx 0 -> 8; idx 4 -> 13; idx 5 with PC=8 -> 4 and with PC=2 -> 1022; all Hit=1, each one cycle after LkEn.
- Same-cycle write idx 7 abs 25 and lookup idx 7 -> next cycle Target=25, Hit=1. Back-to-back lookups idx 0,4,7 -> 8,13,25 on consecutive cycles.
- Program all entries, pulse ClrStart:
  - Busy high exactly 16 cycles.
  - A write to idx 3 mid-sweep is dropped (later lookup idx 3 -> Hit=0).
  - A lookup mid-sweep of an already-programmed, not-yet-cleared entry -> Hit=0.
  - After Busy falls, every lookup -> Hit=0.
- Assert Reset in sweep cycle 5 -> Busy=0 next cycle and all valid bits cleared. Lookup idx 15 -> Hit=0; a following ClrStart restarts the sweep at entry 0.
- Parameter run AW=5, PW=12: 32-cycle sweep; relative entry 0xFFF with PC=0 -> 4095; write/read of idx 31 correct.
